// File: rtl/baggage_drop_ctrl.sv
// baggage_drop_ctrl: weight-qualified timed drop controller with multiplexed 7-segment status display
module baggage_drop_ctrl #(
  parameter int W = 16,
  parameter int DIGITS = 4,
  parameter int SETTLE = 8,
  parameter int DROP_CYCLES = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      t_act,
  input  logic [W-1:0]      t_lim,
  input  logic              drop_en,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] digit_sel,
  output logic              drop_activated,
  output logic              busy
);
  localparam int CMAX = SETTLE > DROP_CYCLES ? SETTLE : DROP_CYCLES;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] DROP_LAST = CW'(DROP_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0] G_DASH = 7'b1000000, G_H = 7'b1110110, G_SO = 7'b1011100,
                         G_L = 7'b0111000, G_D = 7'b1011110, G_R = 7'b1010000,
                         G_O = 7'b0111111, G_P = 7'b1110011, G_F = 7'b1110001,
                         G_U = 7'b0111110;
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_DROP, S_HOLD, S_REJECT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic [27:0] word;
  logic [6:0] seg_n;
  logic ok, over;
  assign ok = drop_en && t_act != '0 && t_act <= t_lim;
  assign over = drop_en && t_act > t_lim;
  assign drop_activated = state == S_DROP;
  assign busy = state != S_IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      S_IDLE: begin
        state_n = over ? S_REJECT : ok ? S_SETTLE : S_IDLE;
        cnt_n = '0;
      end
      S_SETTLE: begin
        state_n = over ? S_REJECT : !ok ? S_IDLE : cnt == SET_LAST ? S_DROP : S_SETTLE;
        cnt_n = (over || !ok || cnt == SET_LAST) ? '0 : cnt + CW'(1);
      end
      S_DROP: begin
        state_n = cnt == DROP_LAST ? S_HOLD : S_DROP;
        cnt_n = cnt == DROP_LAST ? '0 : cnt + CW'(1);
      end
      S_HOLD: state_n = drop_en ? S_HOLD : S_IDLE;
      S_REJECT: state_n = over ? S_REJECT : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  // word is {digit3, digit2, digit1, digit0}; digit 0 is rightmost
  assign word = state == S_IDLE ? {4{G_DASH}} :
                state == S_SETTLE ? {G_H, G_SO, G_L, G_D} :
                state == S_REJECT ? {G_F, G_U, G_L, G_L} : {G_D, G_R, G_O, G_P};
  assign seg_n = int'(idx) < 4 ? word[7*int'(idx[1:0]) +: 7] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      div <= '0;
      idx <= '0;
      seg <= '0;
      digit_sel <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      seg <= seg_n;
      digit_sel <= DIGITS'(1) << idx;
      div <= div == DIV_LAST ? '0 : div + DW'(1);
      if (div == DIV_LAST) idx <= idx == IDX_LAST ? '0 : idx + IW'(1);
    end
  end
endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// tb_baggage_drop_ctrl: vector table, corner sequences and randomized model check of baggage_drop_ctrl
module tb_baggage_drop_ctrl;
  logic clk = 0, rst = 1, drop_en = 0;
  logic [15:0] t_act = 0, t_lim = 0;
  logic [6:0] seg0, seg1;
  logic [3:0] sel0;
  logic [5:0] sel1;
  logic drop0, drop1, busy0, busy1;
  int total = 0, passed = 0;
  always #5 clk = ~clk;

  baggage_drop_ctrl dut (.clk(clk), .rst(rst), .t_act(t_act), .t_lim(t_lim), .drop_en(drop_en),
    .seg(seg0), .digit_sel(sel0), .drop_activated(drop0), .busy(busy0));
  baggage_drop_ctrl #(.W(16), .DIGITS(6), .SETTLE(1), .DROP_CYCLES(4), .SCAN_DIV(1)) dut_p (
    .clk(clk), .rst(rst), .t_act(t_act), .t_lim(t_lim), .drop_en(drop_en),
    .seg(seg1), .digit_sel(sel1), .drop_activated(drop1), .busy(busy1));

  int p_set[2] = '{8, 1};
  int p_dg[2] = '{4, 6};
  int p_sd[2] = '{4, 1};
  int p_dc[2] = '{4, 4};
  string words[5] = '{"----", "HoLd", "drOP", "drOP", "FULL"};
  int m_st[2], m_run[2], m_left[2], m_n[2];
  logic [6:0] m_seg[2];
  logic [7:0] m_sel[2];

  function automatic logic [6:0] glyph(byte c);
    case (c)
      "-": return 7'b1000000;
      "H": return 7'b1110110;
      "o": return 7'b1011100;
      "L": return 7'b0111000;
      "d": return 7'b1011110;
      "r": return 7'b1010000;
      "O": return 7'b0111111;
      "P": return 7'b1110011;
      "F": return 7'b1110001;
      "U": return 7'b0111110;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic model_step();
    logic ok, ov;
    int d;
    ok = drop_en && t_act != 0 && t_act <= t_lim;
    ov = drop_en && t_act > t_lim;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_st[i] = 0; m_run[i] = 0; m_left[i] = 0; m_n[i] = 0; m_seg[i] = 0; m_sel[i] = 0;
      end else begin
        m_n[i]++;
        d = ((m_n[i] - 1) / p_sd[i]) % p_dg[i];
        m_sel[i] = 8'(1 << d);
        m_seg[i] = d < 4 ? glyph(words[m_st[i]].getc(3 - d)) : 7'b0;
        case (m_st[i])
          0: if (ov) m_st[i] = 4; else if (ok) begin m_st[i] = 1; m_run[i] = 1; end
          1: if (ov) m_st[i] = 4;
             else if (!ok) m_st[i] = 0;
             else if (m_run[i] == p_set[i]) begin m_st[i] = 2; m_left[i] = p_dc[i]; end
             else m_run[i]++;
          2: begin m_left[i]--; if (m_left[i] == 0) m_st[i] = 3; end
          3: if (!drop_en) m_st[i] = 0;
          default: if (!ov) m_st[i] = 0;
        endcase
      end
    end
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    else passed++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("m0_seg", 8'(seg0), 8'(m_seg[0]));
    chk("m0_sel", 8'(sel0), m_sel[0]);
    chk("m0_drop", 8'(drop0), 8'(m_st[0] == 2));
    chk("m0_busy", 8'(busy0), 8'(m_st[0] != 0));
    chk("m1_seg", 8'(seg1), 8'(m_seg[1]));
    chk("m1_sel", 8'(sel1), m_sel[1]);
    chk("m1_drop", 8'(drop1), 8'(m_st[1] == 2));
    chk("m1_busy", 8'(busy1), 8'(m_st[1] != 0));
  endtask

  typedef struct {logic r; logic [15:0] a, l; logic en, ed, eb;} vec_t;
  vec_t tv[$];

  task automatic add(int n, logic r, int a, int l, logic en, logic ed, logic eb);
    vec_t v;
    v.r = r; v.a = 16'(a); v.l = 16'(l); v.en = en; v.ed = ed; v.eb = eb;
    for (int k = 0; k < n; k++) tv.push_back(v);
  endtask

  initial begin
    int k;
    add(3, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 500, 0, 0, 0);
    add(8, 0, 500, 500, 1, 0, 1);
    add(4, 0, 500, 500, 1, 1, 1);
    add(2, 0, 500, 500, 1, 0, 1);
    add(1, 0, 500, 500, 0, 0, 0);
    add(2, 0, 501, 500, 1, 0, 1);
    add(1, 0, 400, 500, 1, 0, 0);
    add(1, 0, 400, 500, 1, 0, 1);
    foreach (tv[i]) begin
      rst = tv[i].r; t_act = tv[i].a; t_lim = tv[i].l; drop_en = tv[i].en;
      cycle();
      chk($sformatf("vec%0d_drop", i), 8'(drop0), 8'(tv[i].ed));
      chk($sformatf("vec%0d_busy", i), 8'(busy0), 8'(tv[i].eb));
    end
    // idle scan frame: each digit shows '-' for four cycles
    rst = 1; cycle(); rst = 0; drop_en = 0; t_act = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      chk("idle_sel", 8'(sel0), 8'(1 << (i / 4)));
      chk("idle_seg", 8'(seg0), 8'b01000000);
    end
    // settle abort at count 5, then full restart
    rst = 1; cycle(); rst = 0; t_act = 500; t_lim = 500; drop_en = 1;
    cycle();
    chk("p_drop_e0", 8'(drop1), 8'd0);
    cycle();
    chk("p_drop_e1", 8'(drop1), 8'd1);
    repeat (4) cycle();
    drop_en = 0; cycle();
    chk("abort_busy", 8'(busy0), 8'd0);
    drop_en = 1;
    k = 0;
    do begin cycle(); k++; end while (!drop0 && k < 20);
    chk("abort_latency", 8'(k), 8'd9);
    // reset during the second drop cycle
    cycle();
    chk("mid_drop_high", 8'(drop0), 8'd1);
    rst = 1; cycle();
    chk("rst_drop", 8'(drop0), 8'd0);
    chk("rst_busy", 8'(busy0), 8'd0);
    chk("rst_sel", 8'(sel0), 8'd0);
    rst = 0; drop_en = 0; cycle();
    chk("restart_sel", 8'(sel0), 8'd1);
    chk("restart_seg", 8'(seg0), 8'b01000000);
    // randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(11) == 0) begin
        if ($urandom_range(3) == 0) t_lim = 16'($urandom_range(1, 60000));
        case ($urandom_range(4))
          0: t_act = 0;
          1: t_act = t_lim - 16'd1;
          2: t_act = t_lim;
          3: t_act = t_lim + 16'd1;
          default: t_act = 16'($urandom);
        endcase
        drop_en = $urandom_range(7) != 0;
      end
      rst = $urandom_range(399) == 0;
      cycle();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/baggage_drop_ctrl.md
# baggage_drop_ctrl

Parametrised, clocked successor of the combinational weight-check/display block in the baggage-drop system. Checks the measured bag weight `t_act` against the limit `t_lim` and requires a stable, in-limit reading for a programmable settle time before firing a timed `drop_activated` pulse. It drives a multiplexed seven-segment display of configurable digit count with the status word for each state. The block sits between the scale front-end and the belt/drop actuator and the operator display.

## Interface
Parameters:
- `W`, 16: width of `t_act` / `t_lim`, unsigned.
- `DIGITS`, 4: number of display digits; must be ≥ 4.
- `SETTLE`, 8: consecutive valid cycles required before drop; must be ≥ 1.
- `DROP_CYCLES`, 4: length of the `drop_activated` pulse in cycles; must be ≥ 1.
- `SCAN_DIV`, 4: clock cycles each digit stays selected; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; one clock domain; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `t_act`  in  W  measured weight; 0 means no bag present.
- `t_lim`  in  W  weight limit; `t_act == t_lim` is accepted.
- `drop_en`  in  1  operator/system drop request.
- `seg`  out  7  segment pattern `{g,f,e,d,c,b,a}`, active-high, registered.
- `digit_sel`  out  DIGITS  one-hot digit enable, active-high, registered; bit 0 is the rightmost digit.
- `drop_activated`  out  1  drop actuator command, registered.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `ok = drop_en && t_act != 0 && t_act <= t_lim`, using an unsigned compare. `over = drop_en && t_act > t_lim`.
- FSM states: IDLE, SETTLE, DROP, HOLD, REJECT. Inputs are sampled each edge with no input registers.
- IDLE:
  - `over` → REJECT.
  - else `ok` → SETTLE with `cnt = 0`.
  - else stay in IDLE.
- SETTLE:
  - `over` → REJECT. This takes priority.
  - else `!ok` → IDLE. The count is discarded.
  - else if `cnt == SETTLE-1` → DROP with `cnt = 0`.
  - else `cnt++`.
- DROP: `cnt++` each cycle. When `cnt == DROP_CYCLES-1` → HOLD. Input changes are ignored in this state; the pulse always completes.
- HOLD: stay while `drop_en == 1`; `drop_en == 0` → IDLE. This blocks re-triggering on the same request.
- REJECT: `!over` → IDLE. Re-qualification always restarts from IDLE.
- Output decodes:
  - `drop_activated = (state == DROP)`.
  - `busy = (state != IDLE)`.
- Display word, right-aligned, with digits at index ≥ 4 blank (`0000000`):
  - IDLE: `----`.
  - SETTLE: `HoLd`.
  - DROP and HOLD: `drOP`.
  - REJECT: `FULL`.
- Glyphs `{g..a}`:
  - `-` = 1000000
  - H = 1110110
  - o = 1011100
  - L = 0111000
  - d = 1011110
  - r = 1010000
  - O = 0111111
  - P = 1110011
  - F = 1110001
  - U = 0111110
- Scan:
  - The divider counts 0..SCAN_DIV-1. On wrap, the digit index advances 0..DIGITS-1 and wraps to 0.
  - `digit_sel` and `seg` are registered in the same cycle, so `seg` always matches the selected digit.
  - The word shown follows the current state. A state change is visible on the next register update.
- Counter widths are `$clog2` of the respective maxima, minimum 1 bit. Counters never wrap.

## Timing
- Reset values:
  - state = IDLE, all counters = 0.
  - `seg = 0`, `digit_sel = 0`.
  - `drop_activated = 0`, `busy = 0`.
- First edge after reset release: `digit_sel = 1` and `seg = '-'`.
- Drop latency: `ok` sampled at edge E0 in IDLE → `drop_activated` rises after edge E0+SETTLE. It stays high for exactly DROP_CYCLES cycles, then `busy` stays high in HOLD.
- Single-cycle drop of `ok` during SETTLE → IDLE. A full SETTLE count restarts from zero.
- `over` and `!ok` in the same cycle resolve to REJECT.
- Reset asserted mid-DROP: `drop_activated = 0` and `busy = 0` after that edge, and the display restarts from digit 0.
- Each digit is held for SCAN_DIV cycles; a full frame takes `DIGITS*SCAN_DIV` cycles.

## Test plan
- Reset and idle: `rst` high for 3 cycles, then `t_act = 0`, `drop_en = 0` → `busy = 0` and `drop_activated = 0`. `digit_sel` cycles 0001→0010→0100→1000 every 4 cycles, with `seg = 1000000` on every digit.
- Nominal drop: `t_lim = 500`, `t_act = 500`, `drop_en = 1` held → `drop_activated` high for cycles 9–12 after first sample. State then stays HOLD showing `drOP`; `drop_en = 0` → IDLE next edge.
- Overweight: `t_lim = 500`, `t_act = 501`, `drop_en = 1` → REJECT next edge and display `FULL`. Setting `t_act = 400` → IDLE, then SETTLE, then drop.
- Settle abort: valid request, `drop_en` low for one cycle at SETTLE count 5 → IDLE. On reassertion, the drop arrives a full 9 edges later.
- Reset mid-drop: `rst` asserted in the 2nd DROP cycle → `drop_activated = 0` and `busy = 0` the following cycle.
- Parametrisation: `DIGITS = 6`, `SCAN_DIV = 1`, `SETTLE = 1` → digits 4–5 blank, a new digit each cycle, and `drop_activated` rises 2 edges after the first valid sample.
